// File: rtl/bicubic_coord_gen.sv
// ---------------------------------------------------------------------------
// bicubic_coord_gen
//
// Horizontal source-coordinate generator for the bicubic scaler. For every
// output pixel of a frame it maps the pixel centre into the source line with
// a Q8.8 step. It then emits the Q8 blend fraction and four edge-clamped
// source tap indices (int-1, int, int+1, int+2) on a valid/ready stream.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   start          one-cycle frame start, honoured only while idle
//   cfg_step       Q8.8 source/destination ratio (256 = 1:1)
//   cfg_src_w      source line width in pixels (>= 1)
//   cfg_dst_w      output pixels per line
//   cfg_dst_h      output lines per frame
//                  (all cfg_* are sampled on the accepted start only)
//   busy           high while a frame is being generated
//   done           one-cycle pulse when a frame completes (or is empty)
//   out_valid      payload valid
//   out_ready      consumer accepts; fire = out_valid & out_ready
//   xBlend         {1'b0, frac[7:0]} Q8 blend fraction
//   coeffOne       constant 256 (1.0 in Q8)
//   coeffHalf      constant 128 (0.5 in Q8)
//   tap0..tap3     clamped source indices for int-1 .. int+2
//   out_last_pix   payload is the last pixel of its line
//   out_last_line  payload belongs to the last line of the frame
// ---------------------------------------------------------------------------
module bicubic_coord_gen #(
  parameter int SRC_W_BITS = 12,
  parameter int LINE_BITS  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           cfg_step,
  input  logic [SRC_W_BITS-1:0] cfg_src_w,
  input  logic [SRC_W_BITS-1:0] cfg_dst_w,
  input  logic [LINE_BITS-1:0]  cfg_dst_h,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8:0]            xBlend,
  output logic [8:0]            coeffOne,
  output logic [8:0]            coeffHalf,
  output logic [SRC_W_BITS-1:0] tap0,
  output logic [SRC_W_BITS-1:0] tap1,
  output logic [SRC_W_BITS-1:0] tap2,
  output logic [SRC_W_BITS-1:0] tap3,
  output logic                  out_last_pix,
  output logic                  out_last_line
);

  // Accumulator is signed Q.8: integer part SRC_W_BITS+1 bits (it can reach
  // -1 at the left edge), 8 fraction bits.
  localparam int ACC_W  = SRC_W_BITS + 9;
  localparam int INT_W  = ACC_W - 8;
  // One extra bit so int-1 .. int+2 never overflow before clamping.
  localparam int CAND_W = INT_W + 1;

  localparam logic signed [ACC_W-1:0] HALF_PIX = ACC_W'(128);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateT;

  // -------------------------------------------------------------------------
  // State and configuration registers
  // -------------------------------------------------------------------------
  stateT                   stateReg, stateNext;
  logic signed [ACC_W-1:0] accReg, accNext;
  logic [15:0]             stepReg, stepNext;
  logic [SRC_W_BITS-1:0]   srcWReg, srcWNext;
  logic [SRC_W_BITS-1:0]   dstWReg, dstWNext;
  logic [LINE_BITS-1:0]    dstHReg, dstHNext;
  logic [SRC_W_BITS-1:0]   pixReg, pixNext;
  logic [LINE_BITS-1:0]    lineReg, lineNext;
  logic                    validReg, validNext;
  logic                    doneReg, doneNext;

  // Registered payload
  logic [7:0]              fracReg;
  logic [SRC_W_BITS-1:0]   tapReg [4];
  logic                    lastPixReg, lastLineReg;

  logic                    fire;
  logic                    loadPayload;
  logic                    inIdle;

  // Configuration as seen by this cycle's load: while idle the only load is
  // the accepting start, so the live cfg inputs are the right source; once
  // running, the latched copies are.
  logic [15:0]             stepSel;
  logic [SRC_W_BITS-1:0]   srcWSel;
  logic [SRC_W_BITS-1:0]   dstWSel;
  logic [LINE_BITS-1:0]    dstHSel;

  logic signed [ACC_W-1:0] lineStart;
  logic signed [ACC_W-1:0] stepExt;

  assign inIdle  = (stateReg == IDLE);
  assign stepSel = inIdle ? cfg_step  : stepReg;
  assign srcWSel = inIdle ? cfg_src_w : srcWReg;
  assign dstWSel = inIdle ? cfg_dst_w : dstWReg;
  assign dstHSel = inIdle ? cfg_dst_h : dstHReg;

  // Centre alignment: src = (dst + 0.5) * step - 0.5, so pixel 0 of every line
  // starts at step/2 - 0.5 source pixels.
  assign lineStart = $signed({{(ACC_W-15){1'b0}}, stepSel[15:1]}) - HALF_PIX;
  assign stepExt   = $signed({{(ACC_W-16){1'b0}}, stepReg});

  assign fire = validReg & out_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      accReg   <= '0;
      stepReg  <= '0;
      srcWReg  <= '0;
      dstWReg  <= '0;
      dstHReg  <= '0;
      pixReg   <= '0;
      lineReg  <= '0;
      validReg <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      accReg   <= accNext;
      stepReg  <= stepNext;
      srcWReg  <= srcWNext;
      dstWReg  <= dstWNext;
      dstHReg  <= dstHNext;
      pixReg   <= pixNext;
      lineReg  <= lineNext;
      validReg <= validNext;
      doneReg  <= doneNext;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state, counters and accumulator
  // -------------------------------------------------------------------------
  always_comb begin
    stateNext   = stateReg;
    accNext     = accReg;
    stepNext    = stepReg;
    srcWNext    = srcWReg;
    dstWNext    = dstWReg;
    dstHNext    = dstHReg;
    pixNext     = pixReg;
    lineNext    = lineReg;
    validNext   = validReg;
    doneNext    = 1'b0;
    loadPayload = 1'b0;

    case (stateReg)
      IDLE: begin
        if (start) begin
          if ((cfg_dst_w != '0) && (cfg_dst_h != '0)) begin
            stepNext    = cfg_step;
            srcWNext    = cfg_src_w;
            dstWNext    = cfg_dst_w;
            dstHNext    = cfg_dst_h;
            accNext     = lineStart;
            pixNext     = '0;
            lineNext    = '0;
            validNext   = 1'b1;
            loadPayload = 1'b1;
            stateNext   = RUN;
          end else begin
            // Empty frame: nothing to emit, just report completion.
            doneNext = 1'b1;
          end
        end
      end

      RUN: begin
        if (fire) begin
          if (lastPixReg) begin
            if (lastLineReg) begin
              // Final pixel of the frame consumed. Payload registers keep
              // their last values; out_valid qualifies them.
              validNext = 1'b0;
              doneNext  = 1'b1;
              stateNext = IDLE;
            end else begin
              // Line wrap without a bubble: pixel 0 of the next line is
              // loaded in the same cycle the last pixel fires.
              accNext     = lineStart;
              pixNext     = '0;
              lineNext    = lineReg + LINE_BITS'(1);
              loadPayload = 1'b1;
            end
          end else begin
            accNext     = accReg + stepExt;
            pixNext     = pixReg + SRC_W_BITS'(1);
            loadPayload = 1'b1;
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Payload decode of the value about to be presented
  // -------------------------------------------------------------------------
  logic signed [INT_W-1:0]  intNext;   // floor(acc / 256), may be -1
  logic signed [CAND_W-1:0] srcWExt;
  logic [SRC_W_BITS-1:0]    tapNext [4];
  logic                     lastPixNext;
  logic                     lastLineNext;

  assign intNext      = accNext[ACC_W-1:8];
  assign srcWExt      = $signed({{(CAND_W-SRC_W_BITS){1'b0}}, srcWSel});
  assign lastPixNext  = (pixNext  == (dstWSel - SRC_W_BITS'(1)));
  assign lastLineNext = (lineNext == (dstHSel - LINE_BITS'(1)));

  for (genvar gi = 0; gi < 4; gi++) begin : gTap
    logic signed [CAND_W-1:0] cand;

    // Tap gi sits at int + gi - 1.
    assign cand = $signed({intNext[INT_W-1], intNext}) + $signed(CAND_W'(gi - 1));

    // Left of the line clamps to 0, right of it to the last source pixel.
    assign tapNext[gi] = (cand < 0)        ? '0 :
                         (cand >= srcWExt) ? (srcWSel - SRC_W_BITS'(1)) :
                                             cand[SRC_W_BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tapReg[gi] <= '0;
      end else if (loadPayload) begin
        tapReg[gi] <= tapNext[gi];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fracReg     <= '0;
      lastPixReg  <= 1'b0;
      lastLineReg <= 1'b0;
    end else if (loadPayload) begin
      fracReg     <= accNext[7:0];
      lastPixReg  <= lastPixNext;
      lastLineReg <= lastLineNext;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy          = (stateReg == RUN);
  assign done          = doneReg;
  assign out_valid     = validReg;
  assign xBlend        = {1'b0, fracReg};
  assign coeffOne      = 9'd256;
  assign coeffHalf     = 9'd128;
  assign tap0          = tapReg[0];
  assign tap1          = tapReg[1];
  assign tap2          = tapReg[2];
  assign tap3          = tapReg[3];
  assign out_last_pix  = lastPixReg;
  assign out_last_line = lastLineReg;

endmodule

// File: tb/tb_bicubic_coord_gen.sv
// ---------------------------------------------------------------------------
// tb_bicubic_coord_gen
//
// Directed bench for bicubic_coord_gen. A frame-level model computes every
// expected payload from the centre-mapping formula. A single negedge compare
// process checks busy/done/out_valid every cycle and the payload on every
// valid cycle. Directed sections then pin specific values captured on fire
// against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_bicubic_coord_gen;

  localparam int SW = 12;
  localparam int LB = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   cfg_step;
  logic [SW-1:0] cfg_src_w;
  logic [SW-1:0] cfg_dst_w;
  logic [LB-1:0] cfg_dst_h;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready;
  logic [8:0]    xBlend;
  logic [8:0]    coeffOne;
  logic [8:0]    coeffHalf;
  logic [SW-1:0] tap0, tap1, tap2, tap3;
  logic          out_last_pix;
  logic          out_last_line;

  bicubic_coord_gen #(.SRC_W_BITS(SW), .LINE_BITS(LB)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_step     (cfg_step),
    .cfg_src_w    (cfg_src_w),
    .cfg_dst_w    (cfg_dst_w),
    .cfg_dst_h    (cfg_dst_h),
    .busy         (busy),
    .done         (done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .xBlend       (xBlend),
    .coeffOne     (coeffOne),
    .coeffHalf    (coeffHalf),
    .tap0         (tap0),
    .tap1         (tap1),
    .tap2         (tap2),
    .tap3         (tap3),
    .out_last_pix (out_last_pix),
    .out_last_line(out_last_line)
  );

  always #5 clk = ~clk;

  typedef struct {
    int frac;
    int t0, t1, t2, t3;
    int lp, ll;
    int eof;
  } pix_t;

  pix_t expQ[$];
  pix_t logQ[$];
  int   logCyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit modelBusy = 1'b0;
  bit doneExp = 1'b0;
  int readyMode = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Source position of output pixel p in Q8: (p + 0.5) * step - 128.
  function automatic pix_t modelPix(input int step, input int srcw, input int p,
                                    input int lp, input int ll);
    pix_t r;
    int acc, ip;
    acc = step / 2 - 128 + p * step;
    if (acc >= 0) ip = acc / 256;
    else          ip = -((-acc + 255) / 256);
    r.frac = acc - ip * 256;
    r.t0   = clampi(ip - 1, 0, srcw - 1);
    r.t1   = clampi(ip,     0, srcw - 1);
    r.t2   = clampi(ip + 1, 0, srcw - 1);
    r.t3   = clampi(ip + 2, 0, srcw - 1);
    r.lp   = lp;
    r.ll   = ll;
    r.eof  = (lp != 0 && ll != 0) ? 1 : 0;
    return r;
  endfunction

  task automatic pushFrame(input int step, input int srcw, input int dw, input int dh);
    for (int l = 0; l < dh; l++)
      for (int p = 0; p < dw; p++)
        expQ.push_back(modelPix(step, srcw, p, (p == dw - 1) ? 1 : 0, (l == dh - 1) ? 1 : 0));
  endtask

  // ------------------------------------------------------------ scoreboard
  initial begin : scoreboard
    pix_t e, got;
    bit   wasBusy;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        expQ.delete();
        modelBusy = 1'b0;
        doneExp   = 1'b0;
      end else begin
        chk("busy",      int'(busy),      int'(modelBusy));
        chk("done",      int'(done),      int'(doneExp));
        chk("out_valid", int'(out_valid), int'(modelBusy));
        if (out_valid && modelBusy && expQ.size() > 0) begin
          e = expQ[0];
          chk("xBlend",        int'(xBlend),        e.frac);
          chk("tap0",          int'(tap0),          e.t0);
          chk("tap1",          int'(tap1),          e.t1);
          chk("tap2",          int'(tap2),          e.t2);
          chk("tap3",          int'(tap3),          e.t3);
          chk("out_last_pix",  int'(out_last_pix),  e.lp);
          chk("out_last_line", int'(out_last_line), e.ll);
        end
        wasBusy = modelBusy;
        doneExp = 1'b0;
        if (out_valid && out_ready) begin
          got.frac = int'(xBlend);
          got.t0 = int'(tap0); got.t1 = int'(tap1);
          got.t2 = int'(tap2); got.t3 = int'(tap3);
          got.lp = int'(out_last_pix); got.ll = int'(out_last_line);
          got.eof = 0;
          logQ.push_back(got);
          logCyc.push_back(cyc);
        end
        if (modelBusy && out_ready && expQ.size() > 0) begin
          e = expQ.pop_front();
          if (e.eof != 0) begin
            modelBusy = 1'b0;
            doneExp   = 1'b1;
          end
        end
        if (start && !wasBusy) begin
          if (cfg_dst_w == '0 || cfg_dst_h == '0) begin
            doneExp = 1'b1;
          end else begin
            pushFrame(int'(cfg_step), int'(cfg_src_w), int'(cfg_dst_w), int'(cfg_dst_h));
            modelBusy = 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------- ready driver
  initial begin : readyDriver
    int phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 0) out_ready = 1'b1;
      else                out_ready = (phase % 3 == 0) ? 1'b1 : 1'b0;
      phase++;
    end
  end

  // ------------------------------------------------------------- helpers
  task automatic startFrame(input int step, input int srcw, input int dw, input int dh);
    @(posedge clk);
    #1;
    cfg_step  = 16'(step);
    cfg_src_w = SW'(srcw);
    cfg_dst_w = SW'(dw);
    cfg_dst_h = LB'(dh);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    cfg_step  = 16'hA5A5;   // config is latched; scramble the inputs
    cfg_src_w = '1;
    cfg_dst_w = '1;
    cfg_dst_h = '1;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_done_seen"}, int'(done), 1);
  endtask

  task automatic clearLog();
    logQ.delete();
    logCyc.delete();
  endtask

  // ---------------------------------------------------------------- main
  initial begin : main
    pix_t m;
    int   n;
    rst = 1'b1;
    start = 1'b0;
    cfg_step = '0;
    cfg_src_w = '0;
    cfg_dst_w = '0;
    cfg_dst_h = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      int'(busy),          0);
    chk("rst_done",      int'(done),          0);
    chk("rst_valid",     int'(out_valid),     0);
    chk("rst_xBlend",    int'(xBlend),        0);
    chk("rst_tap3",      int'(tap3),          0);
    chk("rst_last_line", int'(out_last_line), 0);
    chk("coeffOne",      int'(coeffOne),      256);
    chk("coeffHalf",     int'(coeffHalf),     128);
    rst = 1'b0;

    // Pin the model against hand-computed values.
    m = modelPix(128, 8, 0, 0, 0);
    chk("model_up_p0_frac", m.frac, 192);
    chk("model_up_p0_t3",   m.t3,   1);
    m = modelPix(512, 8, 3, 1, 0);
    chk("model_dn_p3_t1",   m.t1,   6);
    chk("model_dn_p3_t3",   m.t3,   7);

    // 1:1 mapping
    clearLog();
    startFrame(256, 4, 4, 1);
    waitDone("one2one");
    chk("one2one_count", logQ.size(), 4);
    if (logQ.size() == 4) begin
      chk("one2one_p0_t0", logQ[0].t0, 0);
      chk("one2one_p0_t2", logQ[0].t2, 1);
      chk("one2one_p0_t3", logQ[0].t3, 2);
      chk("one2one_p3_t0", logQ[3].t0, 2);
      chk("one2one_p3_t3", logQ[3].t3, 3);
      chk("one2one_p3_lp", logQ[3].lp, 1);
      chk("one2one_p3_ll", logQ[3].ll, 1);
    end

    // 2x upscale
    clearLog();
    startFrame(128, 8, 4, 1);
    waitDone("up");
    chk("up_count", logQ.size(), 4);
    if (logQ.size() == 4) begin
      chk("up_p0_frac", logQ[0].frac, 192);
      chk("up_p1_frac", logQ[1].frac, 64);
      chk("up_p2_frac", logQ[2].frac, 192);
      chk("up_p3_frac", logQ[3].frac, 64);
      chk("up_p0_t2",   logQ[0].t2,   0);
      chk("up_p3_t1",   logQ[3].t1,   1);
    end

    // 2x downscale, two lines, no bubble between lines
    clearLog();
    startFrame(512, 8, 4, 2);
    waitDone("down");
    chk("down_count", logQ.size(), 8);
    if (logQ.size() == 8) begin
      chk("down_p3_t0",     logQ[3].t0, 5);
      chk("down_p3_t3",     logQ[3].t3, 7);
      chk("down_l0_ll",     logQ[3].ll, 0);
      chk("down_l1_p1_t1",  logQ[5].t1, 2);
      chk("down_l1_ll",     logQ[7].ll, 1);
      chk("down_no_bubble", logCyc[7] - logCyc[0], 7);
    end

    // Backpressure
    readyMode = 1;
    clearLog();
    startFrame(256, 4, 4, 1);
    waitDone("bp");
    readyMode = 0;
    chk("bp_count", logQ.size(), 4);
    if (logQ.size() == 4) begin
      chk("bp_p3_t1",    logQ[3].t1, 3);
      chk("bp_stalled",  (logCyc[3] - logCyc[0] > 3) ? 1 : 0, 1);
    end

    // start while busy is ignored
    clearLog();
    startFrame(256, 4, 4, 1);
    @(posedge clk);
    #1;
    cfg_step = 16'd512; cfg_src_w = SW'(8); cfg_dst_w = SW'(2); cfg_dst_h = LB'(1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("busy_start");
    chk("busy_start_count", logQ.size(), 4);

    // Empty frames
    clearLog();
    startFrame(256, 4, 0, 1);
    waitDone("zero_w");
    startFrame(256, 4, 4, 0);
    waitDone("zero_h");
    repeat (2) @(posedge clk);
    #1;
    chk("zero_count", logQ.size(), 0);

    // start in the done cycle: back-to-back frames
    clearLog();
    startFrame(256, 4, 4, 1);
    waitDone("b2b_first");
    cfg_step = 16'd256; cfg_src_w = SW'(4); cfg_dst_w = SW'(4); cfg_dst_h = LB'(1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("b2b_second");
    chk("b2b_count", logQ.size(), 8);
    if (logQ.size() == 8) chk("b2b_gap", logCyc[4] - logCyc[3], 2);

    // Reset mid-frame
    clearLog();
    startFrame(256, 4, 4, 2);
    n = 0;
    while (logQ.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_reached", (logQ.size() >= 2) ? 1 : 0, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_busy",   int'(busy),         0);
    chk("rstmid_valid",  int'(out_valid),    0);
    chk("rstmid_done",   int'(done),         0);
    chk("rstmid_xBlend", int'(xBlend),       0);
    chk("rstmid_tap2",   int'(tap2),         0);
    chk("rstmid_tap3",   int'(tap3),         0);
    chk("rstmid_lp",     int'(out_last_pix), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    clearLog();
    startFrame(256, 4, 4, 2);
    waitDone("after_rst");
    chk("after_rst_count", logQ.size(), 8);
    if (logQ.size() == 8) chk("after_rst_p7_t3", logQ[7].t3, 3);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/bicubic_coord_gen.md
# bicubic_coord_gen

Horizontal source-coordinate generator for the bicubic scaler; it produces the per-output-pixel blend fraction and tap indices that the bicubic weight units and line-buffer readers consume. For each output pixel of a frame it maps the pixel centre into the source line using a Q8.8 step and emits four edge-clamped source tap indices. It also emits the Q8 fraction `xBlend` together with the constant `coeffOne`/`coeffHalf` operands. Output follows a valid/ready stream handshake, so the weight pipeline or its FIFO can apply backpressure.

## Interface
- `SRC_W_BITS`, 12: width of source/destination pixel counts and tap indices.
- `LINE_BITS`, 12: width of destination line count.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `start` in 1: one-cycle frame start; honoured only in IDLE.
- `cfg_step` in 16: Q8.8 source/destination ratio (256 = 1:1); sampled on accepted `start`.
- `cfg_src_w` in SRC_W_BITS: source line width in pixels (≥1); sampled on accepted `start`.
- `cfg_dst_w` in SRC_W_BITS: output pixels per line; sampled on accepted `start`.
- `cfg_dst_h` in LINE_BITS: output lines per frame; sampled on accepted `start`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when the frame completes.
- `out_valid` out 1: payload valid.
- `out_ready` in 1: consumer accepts; transfer ("fire") = valid & ready.
- `xBlend` out 9: `{1'b0, frac[7:0]}`, Q8 fraction t.
- `coeffOne` out 9: constant 9'd256.
- `coeffHalf` out 9: constant 9'd128.
- `tap0`..`tap3` out SRC_W_BITS each: clamped source indices for int-1, int, int+1, int+2.
- `out_last_pix` out 1: payload is the last pixel of its line.
- `out_last_line` out 1: payload belongs to the last line.

## Operation
- FSM has two states.
- **IDLE:**
  - `start`=1 with `cfg_dst_w`≠0 and `cfg_dst_h`≠0: latch config, load acc, go to RUN.
  - `start`=1 with either count 0: stay in IDLE, pulse `done` next cycle, emit no payload.
- **RUN:**
  - Hold the payload while `out_valid` & !`out_ready`.
  - Advance one pixel per fire.
  - Fire on the last pixel of a non-last line: reload acc, increment line counter, clear pixel counter.
  - Fire on the last pixel of the last line: go to IDLE, drop `out_valid`, pulse `done`.
- `start` in RUN is ignored; config inputs are don't-care outside the IDLE accept cycle.
- **Accumulator:** signed, SRC_W_BITS+9 bits, Q.8.
  - Line reload value: acc0 = step/2 − 128, i.e. centre alignment src = (dst+0.5)·step − 0.5.
  - Each fire within a line: acc += step.
- **Payload decode:**
  - int = acc >>> 8 (arithmetic floor, may be −1).
  - frac = acc[7:0].
  - tapk = clamp(int−1+k, 0, src_w−1).
  - Negative values clamp to 0. Positions past the right edge clamp to src_w−1, with no wrap.
- **Registering:** payload and `out_last_*` are registered and change only on fire or on the load from IDLE.
- **Constants:** `coeffOne`/`coeffHalf` are constant ties, independent of reset and state.

## Timing
- **Reset values:**
  - `busy`, `done`, `out_valid`, `out_last_pix`, `out_last_line` = 0.
  - `xBlend` = 0, `tap0`..`tap3` = 0.
  - FSM = IDLE, acc and counters = 0.
- Reset asserted mid-frame aborts immediately. No `done` pulse; outputs take reset values asynchronously.
- Start latency: `start` accepted in cycle N → `out_valid`=1 with pixel 0 in cycle N+1; `busy`=1 from N+1.
- **Throughput:** one payload per cycle while `out_ready`=1, including across line boundaries (no bubble).
- The next payload is visible the cycle after its predecessor fires.
- `done` is asserted in the cycle after the final fire, together with `out_valid`=0 and `busy`=0.
- A new `start` is accepted in the same cycle `done` is high, which allows back-to-back frames.
- `out_valid` never drops without a fire, except on reset.

## Test plan
- **1:1 mapping:** step=256, src_w=4, dst_w=4, dst_h=1, ready=1 →
  - pixels 0..3: frac 0, int 0,1,2,3.
  - pixel 0 taps 0,0,1,2; pixel 3 taps 2,3,3,3 with `out_last_pix`=`out_last_line`=1.
  - `done` one cycle after the last fire.
- **2× upscale:** step=128, src_w=8, dst_w=4 →
  - (int,xBlend): (−1,192), (0,64), (0,192), (1,64).
  - pixel 0 taps 0,0,0,1.
- **2× downscale:** step=512, src_w=8, dst_w=4, dst_h=2 →
  - (int,xBlend) per line: (0,128), (2,128), (4,128), (6,128); pixel 3 taps 5,6,7,7.
  - Line 2 repeats the same values with `out_last_line`=1; 8 fires total with no bubble between lines.
- **Backpressure:** same as the first case with `out_ready` toggling 1,0,0,1,… → payload stable while stalled; no pixel lost or duplicated.
- **Start protocol:**
  - `start` pulsed while busy → ignored, sequence unchanged.
  - `start` with dst_w=0 → no `out_valid`; `done` at N+1.
  - `start` in the `done` cycle → pixel 0 of the new frame on the next cycle.
- **Reset mid-operation:** `rst` asserted at pixel 2 of a 4×2 frame → all outputs 0 immediately, IDLE, no `done`; a following `start` produces a correct full frame.
